// File: rtl/display_pkg.sv
// Shared types, defaults and the digit-select encoder for the display multiplexer.
package display_pkg;

  typedef enum logic {
    BLANK,
    DRIVE
  } state_t;

  localparam int unsigned DEF_REFRESH_DIV = 24000;
  localparam int unsigned DEF_DEAD_CYCLES = 240;
  localparam int unsigned MAX_DIGITS      = 8;

  // One-hot select for digit idx, inverted when the digit enables are active-low.
  function automatic logic [MAX_DIGITS-1:0] sel_encode(input logic [2:0] idx,
                                                       input logic       active_low);
    logic [MAX_DIGITS-1:0] oh;
    oh = MAX_DIGITS'(1) << idx;
    return active_low ? ~oh : oh;
  endfunction

endpackage

// File: rtl/display_mux_ctrl_slot_timer.sv
// Slot counter and digit index; event outputs flag what the next clock edge does.
module slot_timer
  import display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV = DEF_REFRESH_DIV,
  parameter int unsigned DEAD_CYCLES = DEF_DEAD_CYCLES,
  parameter int unsigned NUM_DIGITS  = 2,
  localparam int unsigned CW = $clog2(REFRESH_DIV),
  localparam int unsigned IW = $clog2(NUM_DIGITS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          run,
  output logic [IW-1:0] idx_next,
  output logic          dead_done,
  output logic          slot_wrap,
  output logic          frame_wrap
);

  if (DEAD_CYCLES < 1 || DEAD_CYCLES >= REFRESH_DIV) begin : g_bad_dead
    $error("slot_timer: DEAD_CYCLES must satisfy 1 <= DEAD_CYCLES < REFRESH_DIV");
  end

  logic [CW-1:0] cnt, cnt_next;
  logic [IW-1:0] idx;

  assign slot_wrap  = run && (cnt == CW'(REFRESH_DIV - 1));
  assign dead_done  = run && (cnt == CW'(DEAD_CYCLES - 1));
  assign frame_wrap = slot_wrap && (idx == IW'(NUM_DIGITS - 1));

  always_comb begin
    cnt_next = cnt;
    idx_next = idx;
    if (!run) begin
      cnt_next = '0;
      idx_next = '0;
    end else if (slot_wrap) begin
      cnt_next = '0;
      idx_next = frame_wrap ? '0 : idx + 1'b1;
    end else begin
      cnt_next = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      cnt <= cnt_next;
      idx <= idx_next;
    end
  end

endmodule

// File: rtl/display_mux_ctrl.sv
// Multiplexed seven-segment digit scheduler with dead-time blanking and frame-atomic updates.
// Optional leading-zero suppression is enabled by defining DISPLAY_LEADING_ZERO_BLANK_EN.
module display_mux_ctrl
  import display_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 2,
  parameter int unsigned REFRESH_DIV    = DEF_REFRESH_DIV,
  parameter int unsigned DEAD_CYCLES    = DEF_DEAD_CYCLES,
  parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en,
  input  logic                    upd,
  input  logic [4*NUM_DIGITS-1:0] digit_data,
  output logic [3:0]              sy,
  output logic                    blank,
  output logic [NUM_DIGITS-1:0]   sel,
  output logic                    frame_start
);

  localparam int unsigned IW = $clog2(NUM_DIGITS);
  localparam logic [NUM_DIGITS-1:0] SEL_OFF = {NUM_DIGITS{SEL_ACTIVE_LOW}};

  if (NUM_DIGITS < 2 || NUM_DIGITS > MAX_DIGITS) begin : g_bad_digits
    $error("display_mux_ctrl: NUM_DIGITS must be in 2..8");
  end

  state_t                  state, state_next;
  logic                    running, restart, run;
  logic [4*NUM_DIGITS-1:0] pending, pending_next;
  logic [4*NUM_DIGITS-1:0] active, active_next;
  logic [IW-1:0]           idx_next;
  logic                    dead_done, slot_wrap, frame_wrap;
  logic                    suppress;
  logic [3:0]              sy_next;
  logic [NUM_DIGITS-1:0]   sel_next;
  logic [MAX_DIGITS-1:0]   sel_full;
  logic                    unused_sel_bits;

  // First enabled edge (after reset or en rising) restarts at frame start with counters held at 0.
  assign restart = en && !running;
  assign run     = en && running;

  slot_timer #(
    .REFRESH_DIV (REFRESH_DIV),
    .DEAD_CYCLES (DEAD_CYCLES),
    .NUM_DIGITS  (NUM_DIGITS)
  ) u_slot_timer (
    .clk        (clk),
    .reset      (reset),
    .run        (run),
    .idx_next   (idx_next),
    .dead_done  (dead_done),
    .slot_wrap  (slot_wrap),
    .frame_wrap (frame_wrap)
  );

  always_comb begin
    pending_next = upd ? digit_data : pending;
    active_next  = active;
    if (restart || frame_wrap) active_next = upd ? digit_data : pending;

    suppress = 1'b0;
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    begin
      logic hi_zero;
      hi_zero = 1'b1;
      for (int unsigned k = NUM_DIGITS - 1; k >= 1; k--) begin
        hi_zero = hi_zero && (active_next[4*k +: 4] == 4'h0);
        if (idx_next == IW'(k) && hi_zero) suppress = 1'b1;
      end
    end
`endif

    state_next = state;
    if (!en || restart) begin
      state_next = BLANK;
    end else begin
      unique case (state)
        BLANK: if (dead_done && !suppress) state_next = DRIVE;
        DRIVE: if (slot_wrap) state_next = BLANK;
        default: state_next = BLANK;
      endcase
    end

    sy_next = '0;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (idx_next == IW'(i)) sy_next = active_next[4*i +: 4];
    end

    sel_full = sel_encode(3'(idx_next), SEL_ACTIVE_LOW);
    sel_next = (state_next == DRIVE) ? sel_full[NUM_DIGITS-1:0] : SEL_OFF;
  end

  assign unused_sel_bits = ^sel_full;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= BLANK;
    else        state <= state_next;
  end

  // Outputs are registered from next-cycle values so they line up with cnt and idx.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      running     <= 1'b0;
      pending     <= '0;
      active      <= '0;
      sy          <= '0;
      blank       <= 1'b1;
      sel         <= SEL_OFF;
      frame_start <= 1'b0;
    end else begin
      running     <= en;
      pending     <= pending_next;
      active      <= active_next;
      sy          <= sy_next;
      blank       <= (state_next != DRIVE);
      sel         <= sel_next;
      frame_start <= restart || frame_wrap;
    end
  end

endmodule

// File: tb/tb_display_mux_ctrl.sv
// Directed bench for display_mux_ctrl with a 2-digit, 10-cycle slot, 2-cycle dead-time setup.
module tb_display_mux_ctrl;

  logic       clk;
  logic       reset;
  logic       en;
  logic       upd;
  logic [7:0] data;
  logic [3:0] sy;
  logic       blank;
  logic [1:0] sel;
  logic       frame_start;

  int         errors;
  int         checks;
  int         cyc;
  int         t0;
  logic       off;
  logic [7:0] exp_disp;

  display_mux_ctrl #(
    .NUM_DIGITS     (2),
    .REFRESH_DIV    (10),
    .DEAD_CYCLES    (2),
    .SEL_ACTIVE_LOW (1'b1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .en          (en),
    .upd         (upd),
    .digit_data  (data),
    .sy          (sy),
    .blank       (blank),
    .sel         (sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, want);
    end
  endtask

  // Expected outputs for the current cycle, from its position within the frame.
  task automatic chk_slot();
    int unsigned rel, pos, slot;
    logic [1:0]  es;
    logic        eb, ef;
    logic [3:0]  ey;
    if (off) begin
      check($sformatf("sel_off c%0d", cyc), 32'(sel), 32'h3);
      check($sformatf("blank_off c%0d", cyc), 32'(blank), 32'h1);
      check($sformatf("fs_off c%0d", cyc), 32'(frame_start), 32'h0);
      return;
    end
    rel  = cyc - t0;
    pos  = rel % 10;
    slot = (rel / 10) % 2;
    ey   = (slot == 0) ? exp_disp[3:0] : exp_disp[7:4];
    eb   = (pos < 2);
    es   = eb ? 2'b11 : ((slot == 0) ? 2'b10 : 2'b01);
`ifdef DISPLAY_LEADING_ZERO_BLANK_EN
    if (slot == 1 && exp_disp[7:4] == 4'h0) begin
      eb = 1'b1;
      es = 2'b11;
    end
`endif
    ef = (rel % 20 == 0);
    check($sformatf("sel c%0d", cyc), 32'(sel), 32'(es));
    check($sformatf("blank c%0d", cyc), 32'(blank), 32'(eb));
    check($sformatf("fs c%0d", cyc), 32'(frame_start), 32'(ef));
    check($sformatf("sy c%0d", cyc), 32'(sy), 32'(ey));
  endtask

  initial begin
    clk = 1'b0; reset = 1'b0; en = 1'b1; upd = 1'b0; data = 8'h00;
    errors = 0; checks = 0; cyc = 0; t0 = 0; off = 1'b0; exp_disp = 8'h00;

    repeat (2) @(negedge clk);
    check("rst_sel", 32'(sel), 32'h3);
    check("rst_blank", 32'(blank), 32'h1);
    check("rst_sy", 32'(sy), 32'h0);
    check("rst_fs", 32'(frame_start), 32'h0);

    // Release with an update present on the first edge: shown in the first frame.
    reset = 1'b1; upd = 1'b1; data = 8'h3C;
    @(posedge clk); @(negedge clk);
    cyc = 0; t0 = 0; exp_disp = 8'h3C;
    chk_slot();
    upd = 1'b0;

    for (int c = 1; c <= 138; c++) begin
      @(posedge clk); @(negedge clk);
      cyc = c;
      case (c)
        80:  exp_disp = 8'h5A;
        100: exp_disp = 8'h22;
        120: exp_disp = 8'h77;
        126: off = 1'b1;
        131: begin off = 1'b0; t0 = 131; exp_disp = 8'h96; end
        default: ;
      endcase
      chk_slot();
      upd = 1'b0;
      case (c)
        74:  begin upd = 1'b1; data = 8'h5A; end
        92:  begin upd = 1'b1; data = 8'h11; end
        95:  begin upd = 1'b1; data = 8'h22; end
        119: begin upd = 1'b1; data = 8'h77; end
        125: en = 1'b0;
        127: begin upd = 1'b1; data = 8'h96; end
        130: en = 1'b1;
        default: ;
      endcase
    end

    // Asynchronous reset while digit 0 is driven.
    reset = 1'b0;
    #1;
    check("arst_sel", 32'(sel), 32'h3);
    check("arst_blank", 32'(blank), 32'h1);
    check("arst_sy", 32'(sy), 32'h0);
    check("arst_fs", 32'(frame_start), 32'h0);

    // Buffers were cleared: first frame shows 0x00, then 0x07 from a mid-frame update.
    @(negedge clk);
    reset = 1'b1; upd = 1'b0;
    @(posedge clk); @(negedge clk);
    cyc = 200; t0 = 200; exp_disp = 8'h00;
    chk_slot();
    for (int c = 201; c <= 239; c++) begin
      @(posedge clk); @(negedge clk);
      cyc = c;
      if (c == 220) exp_disp = 8'h07;
      chk_slot();
      upd = 1'b0;
      if (c == 205) begin upd = 1'b1; data = 8'h07; end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
